muldiv_engine: RTL
==================

MULDIV_ENGINE -- requirements
Module: muldiv_engine

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; legal values are even and at least 8.
REQ-002 Parameter MUL_LAT, default 5: multiply/accumulate latency in cycles; legal range 1..16.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: launch the operation selected by op.
REQ-006 Port op, input, 3: operation code (see REQ-014).
REQ-007 Port a / b, input, WIDTH each: rs / rt operands, sampled on the start edge.
REQ-008 Port cancel, input, 1: abort the in-flight operation (pipeline flush).
REQ-009 Port we, input, 1: direct HI/LO write (MTHI/MTLO).
REQ-010 Port hisel, input, 1: with we, 1 selects HI and 0 selects LO.
REQ-011 Port wdata, input, WIDTH: data for the direct write.
REQ-012 Port busy, output, 1: an operation is in flight.
REQ-013 Ports hi / lo, output, WIDTH each: architectural HI / LO registers; done, output, 1: one-cycle completion pulse.

Function
REQ-014 op encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU; signed ops treat a and b as two's complement.
REQ-015 States are IDLE, MUL, DIV and FIX; reset enters IDLE.
REQ-016 IDLE: start=1 captures a, b and op; ops 0,1,4-7 go to MUL and ops 2,3 go to DIV; busy=1 from the next cycle.
REQ-017 MUL: counter runs MUL_LAT cycles after the start edge k.
- Edge k+MUL_LAT writes {HI,LO}: the full 2*WIDTH product for MULT/MULTU, {HI,LO}+product for MADD*, {HI,LO}-product for MSUB*.
- The write is modulo 2^(2*WIDTH).
- State returns to IDLE.
REQ-018 DIV: restoring radix-2 division on operand magnitudes, one quotient bit per cycle for WIDTH cycles, then one FIX cycle.
- Total latency WIDTH+1 edges after the start edge.
- FIX applies signs: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- LO=quotient, HI=remainder.
REQ-019 Divide by zero: identical latency; LO=all ones, HI=a.
REQ-020 Signed overflow (most negative / -1): LO=most negative value, HI=0.
REQ-021 done=1 for exactly the cycle following the HI/LO update edge, and busy=0 in that same cycle.
REQ-022 start while busy=1 is ignored.
- A new start may be accepted in the same cycle done=1.
REQ-023 cancel=1 while busy=1: next state IDLE, busy=0 next cycle, HI/LO unchanged, no done pulse.
- cancel in IDLE has no effect.
- cancel and start in the same cycle in IDLE: start is ignored.
REQ-024 we=1 in IDLE: writes wdata into HI (hisel=1) or LO (hisel=0) at the edge.
- we while busy=1 is ignored.
- we and start in the same IDLE cycle: the write happens first, and MADD/MSUB accumulate onto the post-write HI/LO.
REQ-025 hi/lo are registered outputs with no combinational path from any input.

Reset
REQ-026 reset=0 immediately forces:
- state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- This holds even mid-operation; the operation is discarded.
REQ-027 reset is deasserted synchronously by the system; the first start is accepted on the first edge with reset=1.

Structure
REQ-028 Package muldiv_pkg holds:
- the op encodings (REQ-014);
- the state enumeration;
- an is_signed(op) helper constant function.
REQ-029 The restoring-divider datapath (partial remainder, quotient shift register, per-step subtract) is sub-module div_iter.
- div_iter has ports clk, reset, load, step, dividend, divisor, quot, rem.
- muldiv_engine owns the FSM, the counter, the sign handling and HI/LO.

Verification (WIDTH=32, MUL_LAT=5)
REQ-030 MULT a=0xFFFFFFFD (-3), b=7 at edge k -> busy for 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB after edge k+5; done=1 for one cycle.
REQ-031 DIVU a=100, b=7 at edge k -> hi=2, lo=14 after edge k+33; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Accumulate and zero divisor:
- we/hisel=0 writes lo=5 and hi=0, then MADD a=3, b=4 -> lo=17, hi=0.
- MSUB a=1, b=18 -> hi:lo=0xFFFFFFFF:0xFFFFFFFF.
- DIV b=0 with a=9 -> lo=0xFFFFFFFF, hi=9.
REQ-033 Cancel: DIV started, cancel at cycle 10 -> busy=0 next cycle, hi/lo hold their prior values, no done; a start issued while busy is ignored.
REQ-034 Reset: reset=0 asserted asynchronously mid-MUL -> hi=lo=0 and busy=0 immediately; after release, MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and op helpers for the multiply/divide engine
//
// Purpose : common definitions imported by muldiv_engine, div_iter and the interface users.
// Contents: opE    - 3-bit operation encoding (MULT..MSUBU)
//           stateE - engine FSM states (IDLE, MUL, DIV, FIX)
//           is_signed(op) - 1 for the two's complement flavours of each op
//           isDiv(op)     - 1 for DIV / DIVU
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } opE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } stateE;

  // Even codes are the signed variants of each operation pair.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic isDiv(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_engine_if.sv
// rtl/muldiv_engine_if.sv - command / HI-LO bus between a requester and the multiply/divide engine
//
// Purpose : bundles the operation request, direct HI/LO write and result signals.
// Signals : start, op, a, b   - operation launch and operands
//           cancel            - abort an in-flight operation
//           we, hisel, wdata  - direct HI/LO write
//           busy, done        - status and one-cycle completion pulse
//           hi, lo            - architectural HI / LO registers
// Modports: master drives requests, slave (the engine) drives status and HI/LO.
interface muldiv_engine_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             we;
  logic             hisel;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, we, hisel, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, we, hisel, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_engine_div_iter.sv
// rtl/muldiv_engine_div_iter.sv - restoring radix-2 unsigned divider datapath, one quotient bit per step
//
// Purpose : holds the partial remainder, quotient shift register and divisor;
//           each step shifts one dividend bit into the remainder and trial-subtracts.
// Ports   : clk, reset (async, active-low)
//           load     - capture dividend/divisor, clear the remainder
//           step     - perform one restoring iteration
//           dividend, divisor - unsigned magnitudes
//           quot, rem         - running quotient / remainder (final after WIDTH steps)
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quotReg;
  logic [WIDTH-1:0] dsrReg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Dividend bits leave from the top of the quotient register as quotient
  // bits enter at the bottom. While rem < divisor, shifted < 2*divisor, so the
  // top bit of diff is a reliable borrow flag.
  assign shifted = {remReg, quotReg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsrReg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remReg  <= '0;
      quotReg <= '0;
      dsrReg  <= '0;
    end else if (load) begin
      remReg  <= '0;
      quotReg <= dividend;
      dsrReg  <= divisor;
    end else if (step) begin
      remReg  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quotReg <= {quotReg[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  assign quot = quotReg;
  assign rem  = remReg;

endmodule

// File: rtl/muldiv_engine.sv
// rtl/muldiv_engine.sv - MIPS-style HI/LO multiply, multiply-accumulate and divide engine
//
// Purpose : executes MULT/MULTU/MADD*/MSUB* with a fixed MUL_LAT latency and
//           DIV/DIVU with a WIDTH-step restoring divider plus one sign-fix cycle.
// Ports   : clk          - clock, rising edge
//           reset        - asynchronous, active-low
//           bus (slave)  - start/op/a/b, cancel, we/hisel/wdata in;
//                          busy, done, hi, lo out (all registered)
module muldiv_engine
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic            clk,
  input logic            reset,
  muldiv_engine_if.slave bus
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  stateE            stateReg;
  logic [CNT_W-1:0] cntReg;
  logic [2:0]       opReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             busyReg;
  logic             doneReg;

  // ---------------- multiply / accumulate ----------------
  // Extending both operands to 2*WIDTH and keeping the low half gives the
  // correct two's complement product without a separate signed multiplier.
  logic [2*WIDTH-1:0] extA;
  logic [2*WIDTH-1:0] extB;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] accum;
  logic [2*WIDTH-1:0] mulResult;

  assign extA    = is_signed(opReg) ? {{WIDTH{aReg[WIDTH-1]}}, aReg} : {{WIDTH{1'b0}}, aReg};
  assign extB    = is_signed(opReg) ? {{WIDTH{bReg[WIDTH-1]}}, bReg} : {{WIDTH{1'b0}}, bReg};
  assign product = extA * extB;
  // HI/LO cannot change while busy, so reading them at completion sees the
  // value left by any direct write made on the start edge.
  assign accum   = {hiReg, loReg};
  assign mulResult = !opReg[2] ? product :
                     (opReg[1] ? accum - product : accum + product);

  // ---------------- divide ----------------
  logic             startSigned;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic             accept;
  logic             divLoad;
  logic             divStep;
  logic [WIDTH-1:0] divQuot;
  logic [WIDTH-1:0] divRem;

  // Magnitudes are taken from the live inputs so the divider loads on the
  // start edge itself; the most negative value maps to 2^(WIDTH-1), which fits.
  assign startSigned = is_signed(bus.op);
  assign aMag = (startSigned && bus.a[WIDTH-1]) ? ZERO - bus.a : bus.a;
  assign bMag = (startSigned && bus.b[WIDTH-1]) ? ZERO - bus.b : bus.b;

  assign accept  = (stateReg == ST_IDLE) && bus.start && !bus.cancel;
  assign divLoad = accept && isDiv(bus.op);
  assign divStep = (stateReg == ST_DIV);

  div_iter #(.WIDTH(WIDTH)) uDiv (
    .clk      (clk),
    .reset    (reset),
    .load     (divLoad),
    .step     (divStep),
    .dividend (aMag),
    .divisor  (bMag),
    .quot     (divQuot),
    .rem      (divRem)
  );

  logic             opSigned;
  logic             qNeg;
  logic             rNeg;
  logic             divZero;
  logic             divOvf;
  logic [WIDTH-1:0] fixHi;
  logic [WIDTH-1:0] fixLo;

  assign opSigned = is_signed(opReg);
  assign qNeg     = opSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
  assign rNeg     = opSigned && aReg[WIDTH-1];
  assign divZero  = (bReg == ZERO);
  assign divOvf   = opSigned && (aReg == MOST_NEG) && (bReg == '1);

  always_comb begin
    fixHi = rNeg ? ZERO - divRem : divRem;
    fixLo = qNeg ? ZERO - divQuot : divQuot;
    if (divZero) begin
      fixHi = aReg;
      fixLo = '1;
    end else if (divOvf) begin
      fixHi = '0;
      fixLo = MOST_NEG;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= ST_IDLE;
      cntReg   <= '0;
      opReg    <= '0;
      aReg     <= '0;
      bReg     <= '0;
      hiReg    <= '0;
      loReg    <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        ST_IDLE: begin
          if (bus.we) begin
            if (bus.hisel) hiReg <= bus.wdata;
            else           loReg <= bus.wdata;
          end
          if (accept) begin
            opReg   <= bus.op;
            aReg    <= bus.a;
            bReg    <= bus.b;
            busyReg <= 1'b1;
            if (isDiv(bus.op)) begin
              stateReg <= ST_DIV;
              cntReg   <= DIV_LOAD;
            end else begin
              stateReg <= ST_MUL;
              cntReg   <= MUL_LOAD;
            end
          end
        end
        ST_MUL: begin
          if (bus.cancel) begin
            stateReg <= ST_IDLE;
            busyReg  <= 1'b0;
            cntReg   <= '0;
          end else if (cntReg == '0) begin
            {hiReg, loReg} <= mulResult;
            doneReg  <= 1'b1;
            busyReg  <= 1'b0;
            stateReg <= ST_IDLE;
          end else begin
            cntReg <= cntReg - CNT_ONE;
          end
        end
        ST_DIV: begin
          if (bus.cancel) begin
            stateReg <= ST_IDLE;
            busyReg  <= 1'b0;
            cntReg   <= '0;
          end else if (cntReg == '0) begin
            stateReg <= ST_FIX;
          end else begin
            cntReg <= cntReg - CNT_ONE;
          end
        end
        ST_FIX: begin
          stateReg <= ST_IDLE;
          busyReg  <= 1'b0;
          if (!bus.cancel) begin
            hiReg   <= fixHi;
            loReg   <= fixLo;
            doneReg <= 1'b1;
          end
        end
        default: begin
          stateReg <= ST_IDLE;
          busyReg  <= 1'b0;
          cntReg   <= '0;
        end
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule
